// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back merge of ALU results and data-memory load results onto
// a single register-file write port. ALU results always win; loads that cannot
// be written immediately wait in a small FIFO. Queued loads that are overwritten
// by a younger ALU write to the same register are killed and later discarded.
// A combinational forwarding port exposes the youngest live queued load value
// for a given register.
module wb_arbiter #(
  parameter int DEPTH     = 4,
  parameter int REG_AW    = 5,
  parameter int DW        = 16,
  parameter bit ZERO_DROP = 1'b1,
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              mem_ena_i,
  input  logic [REG_AW-1:0] mem_adr_i,
  input  logic [DW-1:0]     mem_data_i,
  input  logic              alu_ena_i,
  input  logic [REG_AW-1:0] alu_adr_i,
  input  logic [DW-1:0]     alu_data_i,
  input  logic [REG_AW-1:0] fwd_adr_i,
  output logic              fwd_hit_o,
  output logic [DW-1:0]     fwd_data_o,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_adr_o,
  output logic [DW-1:0]     rf_data_o,
  output logic              full_o,
  output logic [CW-1:0]     count_o,
  output logic              ovf_o
);

  // Load FIFO storage. Pointers carry one extra wrap bit so that full and
  // empty are distinguishable from the pointer difference alone.
  logic [REG_AW-1:0] adr_q  [DEPTH];
  logic [DW-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0]  kill_q, kill_d;
  logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;

  // Registered register-file write port and sticky overflow flag.
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_adr_q, rf_adr_d;
  logic [DW-1:0]     rf_data_q, rf_data_d;
  logic              ovf_q, ovf_d;

  // Per-cycle decode.
  logic              mem_v, alu_v;
  logic [CW-1:0]     count;
  logic              empty, full;
  logic [PW-1:0]     wr_idx, rd_idx;
  logic              head_live, head_dead;
  logic              mem_waw;
  logic              bypass;
  logic              push, pop;

  // Input filtering, occupancy and head-of-queue status.
  always_comb begin
    mem_v     = mem_ena_i && !(ZERO_DROP && (mem_adr_i == '0));
    alu_v     = alu_ena_i && !(ZERO_DROP && (alu_adr_i == '0));
    count     = wr_ptr_q - rd_ptr_q;
    empty     = (count == '0);
    full      = (count == CW'(DEPTH));
    wr_idx    = wr_ptr_q[PW-1:0];
    rd_idx    = rd_ptr_q[PW-1:0];
    head_live = !empty && !kill_q[rd_idx];
    head_dead = !empty &&  kill_q[rd_idx];
    // A load racing an ALU write to the same register is the older value and
    // would be overwritten immediately, so it is consumed without effect.
    mem_waw   = alu_v && mem_v && (mem_adr_i == alu_adr_i);
  end

  // Source selection for the write port, FIFO push/pop, WAW kill marking.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    rf_we_d   = 1'b0;
    rf_adr_d  = rf_adr_q;
    rf_data_d = rf_data_q;
    ovf_d     = ovf_q;
    kill_d    = kill_q;
    bypass    = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;

    if (alu_v) begin
      rf_we_d   = 1'b1;
      rf_adr_d  = alu_adr_i;
      rf_data_d = alu_data_i;
    end else if (head_live) begin
      rf_we_d   = 1'b1;
      rf_adr_d  = adr_q[rd_idx];
      rf_data_d = data_q[rd_idx];
      pop       = 1'b1;
    end else if (head_dead) begin
      // Killed head leaves the queue without using the write port.
      pop = 1'b1;
    end else if (mem_v) begin
      // Only reachable with an empty FIFO: the load goes straight through.
      rf_we_d   = 1'b1;
      rf_adr_d  = mem_adr_i;
      rf_data_d = mem_data_i;
      bypass    = 1'b1;
    end

    if (mem_v && !bypass && !mem_waw) begin
      if (!full || pop) begin
        push = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (alu_v) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (adr_q[i] == alu_adr_i) begin
          kill_d[i] = 1'b1;
        end
      end
    end

    // A freshly pushed slot always starts live; stale kill state from an
    // earlier occupant must not leak into it.
    if (push) begin
      kill_d[wr_idx] = 1'b0;
    end

    wr_ptr_d = wr_ptr_q + CW'(push);
    rd_ptr_d = rd_ptr_q + CW'(pop);
  end

  // Forwarding scan: walk queued entries oldest to youngest so the youngest
  // live match is the one left standing.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_idx + PW'(k);
      if ((CW'(k) < count) && !kill_q[idx] && (adr_q[idx] == fwd_adr_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_q[idx];
      end
    end
  end

  // Control state and output register update with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is assigned with <= so every flop samples the
    // values computed before this edge, independent of statement order.
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      kill_q    <= '0;
      rf_we_q   <= 1'b0;
      rf_adr_q  <= '0;
      rf_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      kill_q    <= kill_d;
      rf_we_q   <= rf_we_d;
      rf_adr_q  <= rf_adr_d;
      rf_data_q <= rf_data_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO payload write on push.
  always_ff @(posedge clk_i) begin
    // NOTE: payload storage is deliberately not reset; the pointers and kill
    // bits define which slots are meaningful, so stale data is never observed.
    if (push) begin
      adr_q[wr_idx]  <= mem_adr_i;
      data_q[wr_idx] <= mem_data_i;
    end
  end

  assign rf_we_o   = rf_we_q;
  assign rf_adr_o  = rf_adr_q;
  assign rf_data_o = rf_data_q;
  assign ovf_o     = ovf_q;
  assign full_o    = full;
  assign count_o   = count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios followed by random traffic.
// A queue-based reference model predicts every register-file write; those
// predictions go into a scoreboard that an independent monitor drains.
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst   = 1'b1;
  logic          mem_ena_i = 1'b0;
  logic [AW-1:0] mem_adr_i = '0;
  logic [DW-1:0] mem_data_i = '0;
  logic          alu_ena_i = 1'b0;
  logic [AW-1:0] alu_adr_i = '0;
  logic [DW-1:0] alu_data_i = '0;
  logic [AW-1:0] fwd_adr_i = '0;
  logic          fwd_hit_o;
  logic [DW-1:0] fwd_data_o;
  logic          rf_we_o;
  logic [AW-1:0] rf_adr_o;
  logic [DW-1:0] rf_data_o;
  logic          full_o;
  logic [CW-1:0] count_o;
  logic          ovf_o;

  wb_arbiter #(.DEPTH(DEPTH), .REG_AW(AW), .DW(DW), .ZERO_DROP(1'b1)) dut (
    .clk_i      (clk_i),
    .rst        (rst),
    .mem_ena_i  (mem_ena_i),
    .mem_adr_i  (mem_adr_i),
    .mem_data_i (mem_data_i),
    .alu_ena_i  (alu_ena_i),
    .alu_adr_i  (alu_adr_i),
    .alu_data_i (alu_data_i),
    .fwd_adr_i  (fwd_adr_i),
    .fwd_hit_o  (fwd_hit_o),
    .fwd_data_o (fwd_data_o),
    .rf_we_o    (rf_we_o),
    .rf_adr_o   (rf_adr_o),
    .rf_data_o  (rf_data_o),
    .full_o     (full_o),
    .count_o    (count_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: the load queue as a list of pending loads in age order.
  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
    bit            killed;
  } ent_t;

  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  ent_t fifo_m[$];
  wr_t  exp_q[$];
  bit   ovf_m = 1'b0;

  function automatic void expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
    wr_t w;
    w.adr  = a;
    w.data = d;
    w.cyc  = c;
    exp_q.push_back(w);
  endfunction

  // One clock of stimulus: drive, check combinational/status outputs against
  // the model's current state, then advance the model by one cycle.
  task automatic step(input bit me, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                      input bit ae, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic [AW-1:0] fa);
    bit            mv, av, hit, popped, bypassed;
    logic [DW-1:0] fd;
    int            size_before;
    ent_t          e;
    @(posedge clk_i);
    #2;
    rst        = 1'b0;
    mem_ena_i  = me;
    mem_adr_i  = ma;
    mem_data_i = md;
    alu_ena_i  = ae;
    alu_adr_i  = aa;
    alu_data_i = ad;
    fwd_adr_i  = fa;
    #1;
    hit = 1'b0;
    fd  = '0;
    for (int i = fifo_m.size() - 1; i >= 0; i--) begin
      if (!fifo_m[i].killed && fifo_m[i].adr == fa) begin
        hit = 1'b1;
        fd  = fifo_m[i].data;
        break;
      end
    end
    check("count", 32'(count_o), fifo_m.size());
    check("full", 32'(full_o), 32'(fifo_m.size() == DEPTH));
    check("ovf", 32'(ovf_o), 32'(ovf_m));
    check("fwd", {fwd_hit_o, fwd_data_o}, {hit, fd});

    mv          = me && (ma != 0);
    av          = ae && (aa != 0);
    size_before = fifo_m.size();
    popped      = 1'b0;
    bypassed    = 1'b0;
    if (av) begin
      expect_write(aa, ad, cyc + 1);
    end else if (size_before > 0 && !fifo_m[0].killed) begin
      e = fifo_m.pop_front();
      expect_write(e.adr, e.data, cyc + 1);
      popped = 1'b1;
    end else if (size_before > 0) begin
      void'(fifo_m.pop_front());
      popped = 1'b1;
    end else if (mv) begin
      expect_write(ma, md, cyc + 1);
      bypassed = 1'b1;
    end
    if (av) begin
      foreach (fifo_m[i]) if (fifo_m[i].adr == aa) fifo_m[i].killed = 1'b1;
    end
    if (mv && !bypassed && !(av && ma == aa)) begin
      if (size_before < DEPTH || popped) begin
        e.adr    = ma;
        e.data   = md;
        e.killed = 1'b0;
        fifo_m.push_back(e);
      end else begin
        ovf_m = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n, input logic [AW-1:0] fa = '0);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, fa);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #2;
    rst       = 1'b1;
    mem_ena_i = 1'b0;
    alu_ena_i = 1'b0;
    fifo_m.delete();
    ovf_m = 1'b0;
  endtask

  // Monitor: compares each presented write with the oldest prediction.
  initial begin : monitor
    logic [AW-1:0] hold_adr;
    logic [DW-1:0] hold_data;
    bit            rst_seen;
    wr_t           w;
    hold_adr  = '0;
    hold_data = '0;
    forever begin
      @(posedge clk_i);
      rst_seen = rst;
      @(negedge clk_i);
      if (rst_seen) begin
        hold_adr  = '0;
        hold_data = '0;
        check("reset_out", {rf_we_o, rf_adr_o, rf_data_o}, '0);
      end else if (rf_we_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {rf_adr_o, rf_data_o}, '1);
        end else begin
          w = exp_q.pop_front();
          check("write_data", {rf_adr_o, rf_data_o}, {w.adr, w.data});
          check("write_cycle", cyc, w.cyc);
          hold_adr  = w.adr;
          hold_data = w.data;
        end
      end else begin
        check("hold", {rf_adr_o, rf_data_o}, {hold_adr, hold_data});
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          w = exp_q.pop_front();
          check("missing_write", {rf_adr_o, rf_data_o, 1'b0}, {w.adr, w.data, 1'b1});
        end
      end
    end
  end

  initial begin : stimulus
    // Bypass on empty FIFO.
    step(1, 5'd3, 16'h1234, 0, '0, '0, '0);
    idle(2);

    // ALU priority while loads queue up, then drain in order.
    step(1, 5'd2, 16'h000A, 1, 5'd1, 16'h1111, '0);
    step(1, 5'd4, 16'h000B, 1, 5'd1, 16'h2222, '0);
    step(1, 5'd5, 16'h000C, 1, 5'd1, 16'h3333, '0);
    idle(4);

    // WAW kill of a queued load, then same-cycle mem/ALU collision.
    step(1, 5'd6, 16'hAAAA, 1, 5'd1, 16'h4444, '0);
    step(0, '0, '0, 1, 5'd6, 16'h0055, 5'd6);
    idle(3, 5'd6);
    step(1, 5'd7, 16'hBEEF, 1, 5'd7, 16'h7777, '0);
    idle(2);

    // Fill to full, drop the fifth load, drain.
    for (int i = 0; i < 6; i++)
      step(i < 5, 5'(10 + i), 16'(16'hC000 + i), 1, 5'd1, 16'(16'h5000 + i), '0);
    idle(6);

    // Forwarding: youngest of two loads to r9, then killed by ALU.
    step(1, 5'd9, 16'h0001, 1, 5'd1, 16'h0100, 5'd9);
    step(1, 5'd9, 16'h0002, 1, 5'd1, 16'h0200, 5'd9);
    step(0, '0, '0, 1, 5'd1, 16'h0300, 5'd9);
    step(0, '0, '0, 1, 5'd9, 16'h0400, 5'd9);
    step(0, '0, '0, 1, 5'd1, 16'h0500, 5'd9);
    idle(3, 5'd9);
    // Writes to r0 are ignored on both inputs.
    step(1, 5'd0, 16'hDEAD, 0, '0, '0, '0);
    step(0, '0, '0, 1, 5'd0, 16'hDEAD, '0);
    idle(2);

    // Reset with three loads queued.
    for (int i = 0; i < 3; i++)
      step(1, 5'(20 + i), 16'(16'hE000 + i), 1, 5'd1, 16'h6000, '0);
    do_reset();
    idle(4);

    // Random traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), 16'($urandom),
             $urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), 16'($urandom),
             5'($urandom_range(0, 7)));
      end
    end
    idle(DEPTH + 4);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
